pll_lock_ctrl: RTL and testbench

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

---
 rtl/pll_lock_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
//   Sequences a PLL through free-run settling, acquisition and lock, and
//   watches the PFD activity to declare and drop lock. The reference pulse
//   train and PFD outputs are asynchronous and are synchronized internally.
//
//   Optional feature: define PLL_CTRL_RETRY_EN to make FAULT back off for
//   RETRY_CYC cycles and then re-enter SETTLE. Without it FAULT is held
//   until start drops.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   nrst         asynchronous active-low reset
//   start        level: 1 = run the PLL, 0 = return to IDLE
//   link         asynchronous reference pulse train
//   up, dn       asynchronous PFD outputs
//   freq_rdy     1 forces the VCO to free-run at f0 (SETTLE only)
//   swipt_alive  enables the PLL loop (SETTLE, ACQUIRE, LOCKED)
//   locked       lock indication
//   lock_lost    one-cycle pulse on leaving LOCKED
//   state        current state: IDLE=0 SETTLE=1 ACQUIRE=2 LOCKED=3 FAULT=4
module pll_lock_ctrl #(
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned LOCK_TOL   = 50,
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned LOSS_CNT   = 4,
  parameter int unsigned LINK_TMO   = 4000,
  parameter int unsigned RETRY_CYC  = 10000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       link,
  input  logic       up,
  input  logic       dn,
  output logic       freq_rdy,
  output logic       swipt_alive,
  output logic       locked,
  output logic       lock_lost,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_ACQUIRE = 3'd2,
    S_LOCKED  = 3'd3,
    S_FAULT   = 3'd4
  } state_e;

  // One cycle counter serves the settle timer, the link timeout and the
  // retry back-off: the three are never active in the same state.
  localparam int unsigned CYC_MAX_A = (SETTLE_CYC > LINK_TMO) ? SETTLE_CYC : LINK_TMO;
  localparam int unsigned CYC_MAX   = (CYC_MAX_A > RETRY_CYC) ? CYC_MAX_A : RETRY_CYC;
  localparam int unsigned CW        = $clog2(CYC_MAX + 1);
  localparam int unsigned GW        = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW        = $clog2(LOSS_CNT + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LINK_TMO - 1);
`ifdef PLL_CTRL_RETRY_EN
  localparam logic [CW-1:0] RETRY_LAST  = CW'(RETRY_CYC - 1);
`endif
  localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST    = BW'(LOSS_CNT - 1);
  localparam logic [15:0]   ERR_TOL     = 16'(LOCK_TOL);

  state_e          state_q, state_d;
  logic [2:0]      link_sync_q, link_sync_d;
  logic [1:0]      up_sync_q, up_sync_d;
  logic [1:0]      dn_sync_q, dn_sync_d;
  logic [15:0]     err_acc_q, err_acc_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [GW-1:0]   good_q, good_d;
  logic [BW-1:0]   bad_q, bad_d;
  logic            freq_rdy_q, freq_rdy_d;
  logic            swipt_alive_q, swipt_alive_d;
  logic            locked_q, locked_d;
  logic            lock_lost_q, lock_lost_d;
  logic            ref_edge, err_smp, period_good;

  always_comb begin
    link_sync_d = {link_sync_q[1:0], link};
    up_sync_d   = {up_sync_q[0], up};
    dn_sync_d   = {dn_sync_q[0], dn};

    // Bit 2 only delays the synchronized link for rising-edge detection.
    ref_edge    = link_sync_q[1] & ~link_sync_q[2];
    err_smp     = up_sync_q[1] | dn_sync_q[1];
    period_good = (err_acc_q <= ERR_TOL);

    state_d = state_q;
    cyc_d   = cyc_q;
    good_d  = good_q;
    bad_d   = bad_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cyc_q == SETTLE_LAST) state_d = S_ACQUIRE;
        else                      cyc_d   = cyc_q + 1'b1;
      end
      S_ACQUIRE: begin
        // A reference edge wins over an expiring timeout.
        if (ref_edge) begin
          cyc_d = '0;
          if (!period_good)            good_d  = '0;
          else if (good_q == GOOD_LAST) state_d = S_LOCKED;
          else                          good_d  = good_q + 1'b1;
        end else if (cyc_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_LOCKED: begin
        if (ref_edge) begin
          cyc_d = '0;
          if (period_good)            bad_d   = '0;
          else if (bad_q == BAD_LAST) state_d = S_ACQUIRE;
          else                        bad_d   = bad_q + 1'b1;
        end else if (cyc_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_FAULT: begin
`ifdef PLL_CTRL_RETRY_EN
        if (cyc_q == RETRY_LAST) state_d = S_SETTLE;
        else                     cyc_d   = cyc_q + 1'b1;
`else
        state_d = S_FAULT;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping start overrides every transition above.
    if (state_q != S_IDLE && !start) state_d = S_IDLE;

    // Every state starts with fresh counters.
    if (state_d != state_q) begin
      cyc_d  = '0;
      good_d = '0;
      bad_d  = '0;
    end

    if (state_d == S_IDLE)       err_acc_d = '0;
    else if (ref_edge)           err_acc_d = {15'd0, err_smp};
    else if (err_smp && err_acc_q != '1) err_acc_d = err_acc_q + 1'b1;
    else                         err_acc_d = err_acc_q;

    freq_rdy_d    = (state_d == S_SETTLE);
    swipt_alive_d = (state_d == S_SETTLE) || (state_d == S_ACQUIRE) || (state_d == S_LOCKED);
    locked_d      = (state_d == S_LOCKED);
    lock_lost_d   = (state_q == S_LOCKED) && (state_d != S_LOCKED);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      link_sync_q   <= '0;
      up_sync_q     <= '0;
      dn_sync_q     <= '0;
      err_acc_q     <= '0;
      cyc_q         <= '0;
      good_q        <= '0;
      bad_q         <= '0;
      freq_rdy_q    <= 1'b0;
      swipt_alive_q <= 1'b0;
      locked_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      link_sync_q   <= link_sync_d;
      up_sync_q     <= up_sync_d;
      dn_sync_q     <= dn_sync_d;
      err_acc_q     <= err_acc_d;
      cyc_q         <= cyc_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      freq_rdy_q    <= freq_rdy_d;
      swipt_alive_q <= swipt_alive_d;
      locked_q      <= locked_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign freq_rdy    = freq_rdy_q;
  assign swipt_alive = swipt_alive_q;
  assign locked      = locked_q;
  assign lock_lost   = lock_lost_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: directed lock / loss / timeout / reset scenarios
// with hand-derived timing, followed by a randomized run, all checked each
// cycle against a behavioural model of the lock controller.
module tb_pll_lock_ctrl;

  localparam int SETTLE = 10;
  localparam int TOL    = 3;
  localparam int LCNT   = 4;
  localparam int LOSS   = 2;
  localparam int TMO    = 100;
  localparam int RETRY  = 20;

  localparam int IDLE = 0, SETTLING = 1, ACQ = 2, LOCK = 3, FAULT = 4;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       link = 1'b0;
  logic       up = 1'b0;
  logic       dn = 1'b0;
  logic       freq_rdy, swipt_alive, locked, lock_lost;
  logic [2:0] state;

  always #5 clk = ~clk;

  pll_lock_ctrl #(
    .SETTLE_CYC(SETTLE),
    .LOCK_TOL  (TOL),
    .LOCK_CNT  (LCNT),
    .LOSS_CNT  (LOSS),
    .LINK_TMO  (TMO),
    .RETRY_CYC (RETRY)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .link       (link),
    .up         (up),
    .dn         (dn),
    .freq_rdy   (freq_rdy),
    .swipt_alive(swipt_alive),
    .locked     (locked),
    .lock_lost  (lock_lost),
    .state      (state)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_state = IDLE;
  int m_acc = 0, m_good = 0, m_bad = 0, m_quiet = 0, m_settle = 0, m_retry = 0;
  int m_lost = 0;
  int m_nxt;
  bit m_edge, m_smp, m_okp;
  bit hl[0:2], hu[0:2], hd[0:2];   // input samples from 1, 2, 3 clocks ago

  initial begin
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        m_state = IDLE; m_acc = 0; m_good = 0; m_bad = 0; m_quiet = 0;
        m_settle = 0; m_retry = 0; m_lost = 0;
        for (int k = 0; k < 3; k++) begin hl[k] = 0; hu[k] = 0; hd[k] = 0; end
      end else begin
        // Controller sees inputs after a two-flop delay.
        m_edge = hl[1] && !hl[2];
        m_smp  = hu[1] || hd[1];
        m_okp  = (m_acc <= TOL);
        m_nxt  = m_state;
        if (m_state != IDLE && !start) m_nxt = IDLE;
        else begin
          case (m_state)
            IDLE:     if (start) m_nxt = SETTLING;
            SETTLING: begin m_settle++; if (m_settle >= SETTLE) m_nxt = ACQ; end
            ACQ: begin
              if (m_edge) begin
                m_quiet = 0;
                if (m_okp) begin m_good++; if (m_good >= LCNT) m_nxt = LOCK; end
                else m_good = 0;
              end else begin
                m_quiet++; if (m_quiet >= TMO) m_nxt = FAULT;
              end
            end
            LOCK: begin
              if (m_edge) begin
                m_quiet = 0;
                if (m_okp) m_bad = 0;
                else begin m_bad++; if (m_bad >= LOSS) m_nxt = ACQ; end
              end else begin
                m_quiet++; if (m_quiet >= TMO) m_nxt = FAULT;
              end
            end
            FAULT: begin
`ifdef PLL_CTRL_RETRY_EN
              m_retry++; if (m_retry >= RETRY) m_nxt = SETTLING;
`endif
            end
            default: m_nxt = IDLE;
          endcase
        end
        m_lost = (m_state == LOCK && m_nxt != LOCK) ? 1 : 0;
        if (m_nxt == IDLE) m_acc = 0;
        else if (m_edge) m_acc = m_smp;
        else if (m_smp && m_acc < 65535) m_acc++;
        if (m_nxt != m_state) begin
          m_good = 0; m_bad = 0; m_quiet = 0; m_settle = 0; m_retry = 0;
        end
        m_state = m_nxt;
        hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = link;
        hu[2] = hu[1]; hu[1] = hu[0]; hu[0] = up;
        hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = dn;
      end
    end
  end

  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      check("state", int'(state), m_state);
      check("freq_rdy", int'(freq_rdy), (m_state == SETTLING) ? 1 : 0);
      check("swipt_alive", int'(swipt_alive),
            (m_state == SETTLING || m_state == ACQ || m_state == LOCK) ? 1 : 0);
      check("locked", int'(locked), (m_state == LOCK) ? 1 : 0);
      check("lock_lost", int'(lock_lost), m_lost);
    end
  end

  // ---------------- stimulus ----------------
  int ph = 0, per = 40, cyc = 0;
  bit link_en = 0, up_mode = 0, rand_mode = 0, noisy = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    ph++;
    if (ph >= per) begin
      ph = 0;
      if (rand_mode) begin
        per   = $urandom_range(25, 55);
        noisy = ($urandom_range(0, 2) == 0);
      end
    end
    link = link_en && (ph < per / 2);
    if (rand_mode) begin
      up = noisy && ($urandom_range(0, 3) == 0);
      dn = noisy && ($urandom_range(0, 5) == 0);
    end else begin
      up = up_mode && (ph >= 5) && (ph < 15);
      dn = 1'b0;
    end
  endtask

  task automatic begin_run();
    ph = 0; per = 40; link_en = 1; link = 1'b1; start = 1'b1;
  endtask

  int fr_cnt, t_fall, t_lock, edges, t_lost, t_relock, t_fault, t_retry, pidx, n2;
  bit pat[0:6];

  initial begin
    pat[0] = 0; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 0; pat[5] = 0; pat[6] = 0;

    // Reset values
    step();
    check("rst_state", int'(state), 0);
    check("rst_freq_rdy", int'(freq_rdy), 0);
    check("rst_swipt", int'(swipt_alive), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_lost", int'(lock_lost), 0);
    step(); step();
    nrst = 1'b1;
    step(); step();
    check("idle_hold", int'(state), 0);

    // Settle length and first lock
    begin_run();
    fr_cnt = 0; t_fall = -1; t_lock = -1; edges = 0;
    for (int i = 0; i < 300 && t_lock < 0; i++) begin
      step();
      if (freq_rdy) fr_cnt++;
      if (t_fall < 0 && fr_cnt > 0 && !freq_rdy) t_fall = cyc;
      else if (t_fall >= 0 && ph == 0) edges++;
      if (locked) t_lock = cyc;
    end
    check("settle_len", fr_cnt, 10);
    check("lock_found", int'(t_lock >= 0), 1);
    check("acq_to_lock", t_lock - t_fall, 152);
    check("edges_to_lock", edges, 4);

    // Two bad periods while locked
    up_mode = 1;
    t_lost = -1;
    for (int i = 0; i < 200 && t_lost < 0; i++) begin
      step();
      if (lock_lost) t_lost = cyc;
    end
    check("lost_delay", t_lost - t_lock, 80);
    check("lost_state", int'(state), 2);
    check("lost_locked", int'(locked), 0);

    // good, good, bad, then four good periods
    pidx = 0; up_mode = pat[0];
    step();
    check("lost_width", int'(lock_lost), 0);
    t_relock = -1;
    for (int i = 0; i < 400 && t_relock < 0; i++) begin
      if (ph == 20) begin
        pidx++;
        up_mode = (pidx < 7) ? pat[pidx] : 1'b0;
      end
      step();
      if (locked) t_relock = cyc;
    end
    check("relock_delay", t_relock - t_lost, 280);

    // Reference lost while locked
    link_en = 0; link = 1'b0;
    t_fault = -1;
    for (int i = 0; i < 300 && t_fault < 0; i++) begin
      step();
      if (state == 3'd4) t_fault = cyc;
    end
    check("tmo_delay", t_fault - t_relock, 100);
    check("fault_lost", int'(lock_lost), 1);
    check("fault_swipt", int'(swipt_alive), 0);
`ifdef PLL_CTRL_RETRY_EN
    t_retry = -1;
    for (int i = 0; i < 100 && t_retry < 0; i++) begin
      step();
      if (state == 3'd1) t_retry = cyc;
    end
    check("retry_delay", t_retry - t_fault, 20);
`else
    repeat (60) step();
    check("fault_hold", int'(state), 4);
`endif
    start = 1'b0;
    step();
    check("fault_exit", int'(state), 0);

    // Asynchronous reset mid-ACQUIRE
    step();
    begin_run();
    for (int i = 0; i < 100 && state != 3'd2; i++) step();
    repeat (5) step();
    check("pre_rst_swipt", int'(swipt_alive), 1);
    #2 nrst = 1'b0;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_freq_rdy", int'(freq_rdy), 0);
    check("arst_swipt", int'(swipt_alive), 0);
    check("arst_locked", int'(locked), 0);
    check("arst_lost", int'(lock_lost), 0);
    start = 1'b0; link_en = 0; link = 1'b0;
    step(); step();
    start = 1'b1;
    #2 nrst = 1'b1;
    #1;
    check("rel_state", int'(state), 0);
    step();
    start = 1'b0;
    step(); step();

    // start dropped on the locking reference edge
    begin_run();
    n2 = 0;
    for (int i = 0; i < 300 && n2 < 4; i++) begin
      step();
      if (state == 3'd2 && ph == 2) begin
        n2++;
        if (n2 == 4) start = 1'b0;
      end
    end
    check("drop_reached", n2, 4);
    step();
    check("drop_state", int'(state), 0);
    check("drop_locked", int'(locked), 0);
    check("drop_lost", int'(lock_lost), 0);

    // Randomized run against the model
    step();
    rand_mode = 1; begin_run();
    for (int i = 0; i < 4000; i++) begin
      step();
      start = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 499) == 0) link_en = ~link_en;
      if ($urandom_range(0, 1499) == 0) begin
        #2 nrst = 1'b0;
        #3 nrst = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
